// File: rtl/arb_pkg.sv
// arb_pkg: arbiter state encoding shared by rr_arbiter.
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
endpackage

// File: rtl/one_hot_mux.sv
// one_hot_mux: AND-OR selector driven by a one-hot (or zero) select.
module one_hot_mux #(
  parameter int CH_N = 4,
  parameter int W = 33
) (
  input  logic [CH_N-1:0]        sel,
  input  logic [CH_N-1:0][W-1:0] din,
  output logic [W-1:0]           dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < CH_N; i++) dout |= din[i] & {W{sel[i]}};
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered output stage.
// Defining RR_ARBITER_LOCK_EN holds the grant on one channel until its in_last beat.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int CH_N = 4,
  parameter int PLD_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CH_N-1:0]             in_valid,
  output logic [CH_N-1:0]             in_ready,
  input  logic [CH_N-1:0][PLD_W-1:0]  in_pld,
  input  logic [CH_N-1:0]             in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PLD_W-1:0]            out_pld,
  output logic                        out_last,
  output logic [CH_N-1:0]             out_sel
);
  localparam int PTR_W = CH_N > 1 ? $clog2(CH_N) : 1;
  arb_state_e state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt, lock_ch, lock_nxt, gnt_idx;
  logic [CH_N-1:0] grant, grant_rr, masked, pick;
  logic [CH_N-1:0][PLD_W:0] mux_in;
  logic [PLD_W:0] mux_out;
  logic hs, end_grant;
  // Channels at or above ptr win first; fall back to the lowest valid channel to wrap.
  assign masked = in_valid & ~((CH_N'(1) << ptr) - CH_N'(1));
  assign pick = |masked ? masked : in_valid;
  assign grant_rr = pick & (~pick + CH_N'(1));
  assign grant = state == ARB_LOCKED ? in_valid & (CH_N'(1) << lock_ch) : grant_rr;
  assign in_ready = grant & {CH_N{!out_valid || out_ready}};
  assign hs = |(in_valid & in_ready);
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < CH_N; i++) gnt_idx |= grant[i] ? PTR_W'(i) : '0;
  end
  always_comb begin
    mux_in = '0;
    for (int i = 0; i < CH_N; i++) mux_in[i] = {in_last[i], in_pld[i]};
  end
  one_hot_mux #(.CH_N(CH_N), .W(PLD_W + 1)) u_mux (
    .sel (grant),
    .din (mux_in),
    .dout(mux_out)
  );
  always_comb begin
    state_nxt = state;
    lock_nxt = lock_ch;
    end_grant = 1'b0;
`ifdef RR_ARBITER_LOCK_EN
    if (hs) begin
      end_grant = mux_out[PLD_W];
      state_nxt = mux_out[PLD_W] ? ARB_IDLE : ARB_LOCKED;
      lock_nxt = gnt_idx;
    end
`else
    end_grant = hs;
`endif
    ptr_nxt = end_grant ? (gnt_idx == PTR_W'(CH_N - 1) ? '0 : gnt_idx + 1'b1) : ptr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      ptr <= '0;
      lock_ch <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      lock_ch <= lock_nxt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pld <= '0;
      out_last <= 1'b0;
      out_sel <= '0;
    end else if (hs) begin
      out_valid <= 1'b1;
      {out_last, out_pld} <= mux_out;
      out_sel <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: table-driven bench for rr_arbiter plus packet-lock and reset sequences.
module tb_rr_arbiter;
`ifdef RR_ARBITER_LOCK_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] in_valid, in_ready, in_last, out_sel;
  logic [3:0][31:0] in_pld;
  logic out_valid, out_ready, out_last;
  logic [31:0] out_pld;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic r;
    logic [3:0] e_rdy;
    logic e_ov;
    logic [3:0] e_sel;
    int e_tag;
  } vec_t;
  vec_t tbl[17];
  rr_arbiter #(.CH_N(4), .PLD_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pld(in_pld), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_pld(out_pld), .out_last(out_last), .out_sel(out_sel)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Payload of channel c in a beat tagged t is {t, c}, so the expected out_pld follows from sel and tag.
  task automatic beat(input string nm, input logic [3:0] v, input logic [3:0] l, input logic r,
                      input int in_tag, input logic [3:0] e_rdy, input logic e_ov,
                      input logic [3:0] e_sel, input logic e_last, input int e_tag);
    int ch;
    in_valid = v;
    in_last = l;
    out_ready = r;
    for (int c = 0; c < 4; c++) in_pld[c] = {in_tag[15:0], 16'(c)};
    #1;
    chk({nm, " in_ready"}, 32'(in_ready), 32'(e_rdy));
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, 32'(out_valid), 32'(e_ov));
    if (e_ov) begin
      ch = 0;
      for (int c = 0; c < 4; c++) if (e_sel[c]) ch = c;
      chk({nm, " out_sel"}, 32'(out_sel), 32'(e_sel));
      chk({nm, " out_last"}, 32'(out_last), 32'(e_last));
      chk({nm, " out_pld"}, out_pld, {e_tag[15:0], 16'(ch)});
    end
  endtask
  initial begin
    tbl[0]  = '{v: 4'hF, l: 4'hF, r: 1'b1, e_rdy: 4'b0001, e_ov: 1'b1, e_sel: 4'b0001, e_tag: 0};
    tbl[1]  = '{v: 4'hF, l: 4'hF, r: 1'b1, e_rdy: 4'b0010, e_ov: 1'b1, e_sel: 4'b0010, e_tag: 1};
    tbl[2]  = '{v: 4'hF, l: 4'hF, r: 1'b1, e_rdy: 4'b0100, e_ov: 1'b1, e_sel: 4'b0100, e_tag: 2};
    tbl[3]  = '{v: 4'hF, l: 4'hF, r: 1'b1, e_rdy: 4'b1000, e_ov: 1'b1, e_sel: 4'b1000, e_tag: 3};
    tbl[4]  = '{v: 4'hF, l: 4'hF, r: 1'b1, e_rdy: 4'b0001, e_ov: 1'b1, e_sel: 4'b0001, e_tag: 4};
    tbl[5]  = '{v: 4'hF, l: 4'hF, r: 1'b1, e_rdy: 4'b0010, e_ov: 1'b1, e_sel: 4'b0010, e_tag: 5};
    tbl[6]  = '{v: 4'hF, l: 4'hF, r: 1'b1, e_rdy: 4'b0100, e_ov: 1'b1, e_sel: 4'b0100, e_tag: 6};
    tbl[7]  = '{v: 4'b0101, l: 4'hF, r: 1'b1, e_rdy: 4'b0001, e_ov: 1'b1, e_sel: 4'b0001, e_tag: 7};
    tbl[8]  = '{v: 4'b0101, l: 4'hF, r: 1'b1, e_rdy: 4'b0100, e_ov: 1'b1, e_sel: 4'b0100, e_tag: 8};
    for (int i = 9; i < 14; i++)
      tbl[i] = '{v: 4'hF, l: 4'hF, r: 1'b0, e_rdy: 4'b0000, e_ov: 1'b1, e_sel: 4'b0100, e_tag: 8};
    tbl[14] = '{v: 4'hF, l: 4'hF, r: 1'b1, e_rdy: 4'b1000, e_ov: 1'b1, e_sel: 4'b1000, e_tag: 14};
    tbl[15] = '{v: 4'h0, l: 4'hF, r: 1'b1, e_rdy: 4'b0000, e_ov: 1'b0, e_sel: 4'b0000, e_tag: 0};
    tbl[16] = '{v: 4'h0, l: 4'hF, r: 1'b0, e_rdy: 4'b0000, e_ov: 1'b0, e_sel: 4'b0000, e_tag: 0};
    rst_n = 1'b0;
    in_valid = '0;
    in_last = '0;
    out_ready = 1'b0;
    in_pld = '0;
    #2;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_sel", 32'(out_sel), 32'd0);
    chk("reset out_pld", out_pld, 32'd0);
    chk("reset out_last", 32'(out_last), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++)
      beat($sformatf("row%0d", i), tbl[i].v, tbl[i].l, tbl[i].r, i, tbl[i].e_rdy,
           tbl[i].e_ov, tbl[i].e_sel, 1'b1, tbl[i].e_tag);
    // ch1 packet of three beats competing with ch0; ch1 drops valid before its last beat.
    beat("pkt1", 4'b0010, 4'b0000, 1'b1, 20, 4'b0010, 1'b1, 4'b0010, 1'b0, 20);
    beat("pkt2", 4'b0011, 4'b0000, 1'b1, 21, LK ? 4'b0010 : 4'b0001, 1'b1,
         LK ? 4'b0010 : 4'b0001, 1'b0, 21);
    beat("pkt_gap", 4'b0001, 4'b0000, 1'b1, 22, LK ? 4'b0000 : 4'b0001, !LK, 4'b0001, 1'b0, 22);
    beat("pkt3", 4'b0011, 4'b0010, 1'b1, 23, 4'b0010, 1'b1, 4'b0010, 1'b1, 23);
    beat("after_pkt", 4'b0001, 4'b0001, 1'b1, 24, 4'b0001, 1'b1, 4'b0001, 1'b1, 24);
    // Open a packet on ch2, then reset it away mid-cycle.
    beat("lock2", 4'b0100, 4'b0000, 1'b1, 25, 4'b0100, 1'b1, 4'b0100, 1'b0, 25);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_sel", 32'(out_sel), 32'd0);
    chk("midrst out_pld", out_pld, 32'd0);
    chk("midrst out_last", 32'(out_last), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat("post_rst", 4'b0101, 4'b0101, 1'b1, 26, 4'b0001, 1'b1, 4'b0001, 1'b1, 26);
    beat("post_rst2", 4'b0101, 4'b0101, 1'b1, 27, 4'b0100, 1'b1, 4'b0100, 1'b1, 27);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
